// File: rtl/dot_seq_if.sv
// dot_seq_if: MAC-side bus between the dot-product sequencer and an external MAC unit
// Signals:
//   mac_b, mac_c   weight / input operands
//   mac_st         MAC start level
//   mac_clr        one-cycle accumulator clear pulse
//   mac_result     accumulator value (8-bit float, sign in bit 7)
//   mac_done       MAC done level (may linger from the previous operation)
// Modports: master = sequencer side, slave = MAC side
interface dot_seq_if;
    logic [7:0] mac_b;
    logic [7:0] mac_c;
    logic       mac_st;
    logic       mac_clr;
    logic [7:0] mac_result;
    logic       mac_done;
    modport master (output mac_b, mac_c, mac_st, mac_clr, input mac_result, mac_done);
    modport slave (input mac_b, mac_c, mac_st, mac_clr, output mac_result, mac_done);
endinterface

// File: rtl/dot_seq.sv
// dot_seq: sequences a dot product of up to N_MAX weight/input pairs through an external MAC
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   wr_en/wr_addr/wr_w/wr_x   operand buffer write, accepted only while idle
//   len, relu_en, start       run request; len (clamped to N_MAX) and relu_en sampled on accept
//   busy, done, err, y        run status, completion pulse, MAC timeout flag, held result
//   mac                       MAC bus (dot_seq_if.master)
module dot_seq #(
    parameter int N_MAX   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_w,
    input  logic [7:0] wr_x,
    input  logic [3:0] len,
    input  logic       relu_en,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] y,
    dot_seq_if.master  mac
);
    localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LEN_MAX = 4'(N_MAX);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, ARM, WAIT, RELEASE, FINISH} stateT;

    stateT         state, nextState;
    logic [7:0]    wBuf [N_MAX];
    logic [7:0]    xBuf [N_MAX];
    logic [3:0]    idx, lenQ;
    logic          reluQ, armCnt;
    logic [TW-1:0] waitCnt;
    logic [7:0]    macB, macC;
    wire  [3:0]    idxInc = idx + 4'd1;

    assign mac.mac_b = macB;
    assign mac.mac_c = macC;

    // Buffer has no reset so operands survive a mid-run reset.
    always_ff @(posedge clk)
        if (wr_en && state == IDLE) begin
            wBuf[wr_addr[AW-1:0]] <= wr_w;
            xBuf[wr_addr[AW-1:0]] <= wr_x;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState   = state;
        mac.mac_st  = 1'b0;
        mac.mac_clr = 1'b0;
        case (state)
            IDLE:    nextState = start ? CLEAR : IDLE;
            CLEAR: begin
                mac.mac_clr = 1'b1;
                nextState   = (lenQ == 4'd0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                mac.mac_st = 1'b1;
                nextState  = ARM;
            end
            // mac_done is ignored here so a done left over from the last operation is masked
            ARM: begin
                mac.mac_st = 1'b1;
                nextState  = armCnt ? WAIT : ARM;
            end
            WAIT: begin
                mac.mac_st = 1'b1;
                nextState  = mac.mac_done ? RELEASE : (waitCnt == WAIT_LAST) ? FINISH : WAIT;
            end
            RELEASE: nextState = (idxInc == lenQ) ? FINISH : ISSUE;
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            y       <= 8'h00;
            macB    <= 8'h00;
            macC    <= 8'h00;
            idx     <= 4'd0;
            lenQ    <= 4'd0;
            reluQ   <= 1'b0;
            armCnt  <= 1'b0;
            waitCnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        lenQ  <= (len > LEN_MAX) ? LEN_MAX : len;
                        reluQ <= relu_en;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                // Operands are loaded on entry to ISSUE so they are valid as mac_st rises.
                CLEAR: begin
                    idx  <= 4'd0;
                    macB <= wBuf[0];
                    macC <= xBuf[0];
                end
                ISSUE: armCnt <= 1'b0;
                ARM: begin
                    armCnt  <= 1'b1;
                    waitCnt <= '0;
                end
                WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (!mac.mac_done && waitCnt == WAIT_LAST) err <= 1'b1;
                end
                RELEASE: begin
                    idx  <= idxInc;
                    macB <= wBuf[idxInc[AW-1:0]];
                    macC <= xBuf[idxInc[AW-1:0]];
                end
                FINISH: begin
                    y    <= (lenQ == 4'd0 || err || (reluQ && mac.mac_result[7])) ? 8'h00 : mac.mac_result;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_dot_seq.sv
// tb_dot_seq: directed self-checking bench for dot_seq with a behavioural MAC model
module tb_dot_seq;
    localparam int TMO = 255;

    logic       clk = 0, rst, wr_en, relu_en, start;
    logic [2:0] wr_addr;
    logic [7:0] wr_w, wr_x;
    logic [3:0] len;
    logic       busy, done, err;
    logic [7:0] y;

    dot_seq_if mif();

    dot_seq #(.N_MAX(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_w(wr_w), .wr_x(wr_x),
        .len(len), .relu_en(relu_en), .start(start), .busy(busy), .done(done), .err(err),
        .y(y), .mac(mif)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MAC model: latency counted from the cycle mac_st rises; stale mode keeps done high
    // while idle and for the first three cycles of a new operation.
    int         lat = 6;
    bit         stale = 0, never = 0;
    logic [7:0] macRes = 8'h00;
    int         cnt = 0;
    always @(posedge clk) cnt <= mif.mac_st ? cnt + 1 : 0;
    assign mif.mac_result = macRes;
    assign mif.mac_done = !never && (stale ? (cnt >= lat || cnt < 3) : (mif.mac_st && cnt >= lat));

    logic [7:0] mw [8];
    logic [7:0] mx [8];

    // Per-cycle monitor of the MAC handshake against the buffer model.
    int         rises = 0, clrs = 0, hi = 0;
    bit         prevSt = 0;
    logic [7:0] opB, opC;
    always @(negedge clk) begin
        if (rst) begin
            prevSt = 0;
            hi = 0;
        end else begin
            chk("st_needs_busy", mif.mac_st && !busy, 0);
            if (mif.mac_clr) begin
                clrs++;
                chk("clr_before_ops", rises, 0);
            end
            if (mif.mac_st && !prevSt) begin
                chk("operands", {mif.mac_b, mif.mac_c}, {mw[rises % 8], mx[rises % 8]});
                opB = mif.mac_b;
                opC = mif.mac_c;
                rises++;
                hi = 1;
            end else if (mif.mac_st) begin
                hi++;
                chk("operands_stable", {mif.mac_b, mif.mac_c}, {opB, opC});
            end else if (prevSt) begin
                chk("operands_release", {mif.mac_b, mif.mac_c}, {opB, opC});
                chk("st_high_cycles", hi, never ? TMO + 3 : lat + 1);
            end
            prevSt = mif.mac_st;
        end
    end

    task automatic writeEntry(input int a, input logic [7:0] w, input logic [7:0] x);
        @(negedge clk);
        wr_en = 1; wr_addr = 3'(a); wr_w = w; wr_x = x;
        mw[a] = w; mx[a] = x;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic run(input string name, input logic [3:0] l, input logic r, input int latency,
                       input bit st, input bit nv, input logic [7:0] res, input int hold,
                       input bit wrMid, input logic [7:0] litY, input int litOps);
        int n, expOps, cyc;
        logic [7:0] expY;
        n = (l > 8) ? 8 : int'(l);
        expOps = nv ? (n > 0 ? 1 : 0) : n;
        expY = (n == 0 || nv || (r && res[7])) ? 8'h00 : res;
        lat = latency; stale = st; never = nv; macRes = res;
        rises = 0; clrs = 0;
        @(negedge clk);
        start = 1; len = l; relu_en = r;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc < hold);
            wr_en = wrMid && cyc == 2;
            wr_addr = 0; wr_w = 8'hEE; wr_x = 8'hDD;
            if (cyc == 1) chk({name, ".busy_rise"}, busy, 1);
        end while (!done && cyc < 2000);
        start = 0; wr_en = 0;
        chk({name, ".done_seen"}, done, 1);
        chk({name, ".y_model"}, y, expY);
        chk({name, ".y_literal"}, y, litY);
        chk({name, ".err"}, err, nv && n > 0);
        chk({name, ".ops_model"}, rises, expOps);
        chk({name, ".ops_literal"}, rises, litOps);
        chk({name, ".clr_count"}, clrs, 1);
        chk({name, ".busy_low"}, busy, 0);
        if (l == 0) chk({name, ".len0_latency"}, cyc <= 3, 1);
        @(negedge clk);
        chk({name, ".done_one_cycle"}, done, 0);
        chk({name, ".y_held"}, y, litY);
        chk({name, ".st_low_after"}, mif.mac_st, 0);
    endtask

    initial begin
        int cyc;
        rst = 1; wr_en = 0; wr_addr = 0; wr_w = 0; wr_x = 0; len = 0; relu_en = 0; start = 0;
        #3;
        chk("rst.state", {busy, done, err, mif.mac_st, mif.mac_clr}, 5'b0);
        chk("rst.y", y, 8'h00);
        chk("rst.mac_bc", {mif.mac_b, mif.mac_c}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) writeEntry(i, 8'(16 + 7 * i), 8'(160 - 5 * i));

        run("len3", 4'd3, 1'b0, 6, 1'b0, 1'b0, 8'h3C, 1, 1'b0, 8'h3C, 3);
        run("stale", 4'd3, 1'b0, 6, 1'b1, 1'b0, 8'h25, 3, 1'b0, 8'h25, 3);
        run("len0", 4'd0, 1'b0, 6, 1'b0, 1'b0, 8'h41, 1, 1'b0, 8'h00, 0);
        run("len12", 4'd12, 1'b0, 4, 1'b0, 1'b0, 8'h41, 1, 1'b1, 8'h41, 8);
        run("timeout", 4'd4, 1'b0, 6, 1'b0, 1'b1, 8'h33, 1, 1'b0, 8'h00, 1);
        run("relu_neg", 4'd2, 1'b1, 5, 1'b0, 1'b0, 8'hBC, 1, 1'b0, 8'h00, 2);
        run("relu_pos", 4'd2, 1'b1, 5, 1'b0, 1'b0, 8'h3C, 1, 1'b0, 8'h3C, 2);
        run("norelu", 4'd2, 1'b0, 5, 1'b0, 1'b0, 8'hBC, 1, 1'b0, 8'hBC, 2);

        lat = 6; stale = 0; never = 0; macRes = 8'h77;
        rises = 0; clrs = 0;
        @(negedge clk);
        start = 1; len = 4'd5; relu_en = 0;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (rises < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrun.reach_op2", rises, 2);
        repeat (4) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("midrun.state", {busy, done, err, mif.mac_st, mif.mac_clr}, 5'b0);
        chk("midrun.y", y, 8'h00);
        chk("midrun.mac_bc", {mif.mac_b, mif.mac_c}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        run("after_rst", 4'd3, 1'b0, 4, 1'b0, 1'b0, 8'h5A, 1, 1'b0, 8'h5A, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
